// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch bus: request/address out, ack/data back.
interface pc_fetch_if;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Fetch side drives the request and word address.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Memory side answers with ack and data.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch sequencer.
// FETCH requests the word at pc until ack, HOLD presents the instruction
// to decode until it commits, HALTED is terminal until reset.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] npc,
    input  logic        stall,
    input  logic        halt,
    output logic [29:0] pc,
    pc_fetch_if.master  imem,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] retire_cnt,
    output logic        halted
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]  state;
    logic [29:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] cnt_q;

    // Sequencer: latch on ack in FETCH, commit on !stall in HOLD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_FETCH;
            pc_q    <= RESET_PC[31:2];
            instr_q <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        instr_q <= imem.imem_rdata;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // halt only matters on the commit cycle
                    if (!stall) begin
                        pc_q  <= npc;
                        cnt_q <= cnt_q + 32'd1;
                        state <= halt ? S_HALTED : S_FETCH;
                    end
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Outputs decoded straight from state; address is always pc.
    always_comb begin
        pc             = pc_q;
        instr          = instr_q;
        retire_cnt     = cnt_q;
        imem.imem_req  = (state == S_FETCH);
        imem.imem_addr = pc_q;
        instr_valid    = (state == S_HOLD);
        halted         = (state == S_HALTED);
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: inputs driven and outputs checked on the
// falling edge, expected values computed by hand in the stimulus.
module tb_pc_fetch;
    logic        clk;
    logic        rst;
    logic [29:0] npc;
    logic        stall;
    logic        halt;
    logic [29:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] retire_cnt;
    logic        halted;

    int n_chk;
    int n_fail;

    pc_fetch_if mem ();

    pc_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .stall       (stall),
        .halt        (halt),
        .pc          (pc),
        .imem        (mem.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .retire_cnt  (retire_cnt),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [29:0] a);
        return 32'hA500_0000 ^ {2'b00, a};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    logic [29:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] exp_instr;

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b0; npc = '0; stall = 1'b0; halt = 1'b0;
        mem.imem_ack = 1'b0; mem.imem_rdata = '0;
        step();

        // Reset state
        chk("rst_pc", {2'b0, pc}, 32'h0000_0C00);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_cnt", retire_cnt, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b1;
        step();

        // Zero-wait memory, sequential npc
        exp_pc = 30'h0C00; exp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            chk("seq_req", {31'd0, mem.imem_req}, 32'd1);
            chk("seq_addr", {2'b0, mem.imem_addr}, {2'b0, exp_pc});
            chk("seq_valid0", {31'd0, instr_valid}, 32'd0);
            mem.imem_ack = 1'b1; mem.imem_rdata = rd(exp_pc);
            step();
            mem.imem_ack = 1'b0;
            chk("seq_valid1", {31'd0, instr_valid}, 32'd1);
            chk("seq_instr", instr, rd(exp_pc));
            chk("seq_hold_req", {31'd0, mem.imem_req}, 32'd0);
            chk("seq_pc", {2'b0, pc}, {2'b0, exp_pc});
            npc = exp_pc + 30'd1;
            step();
            exp_pc = exp_pc + 30'd1; exp_cnt = exp_cnt + 1;
            chk("seq_cnt", retire_cnt, exp_cnt);
        end
        chk("seq_pc_end", {2'b0, pc}, 32'h0000_0C03);

        // Delayed ack at 0x3000 after a fresh reset
        rst = 1'b0; #1; rst = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("dly_req", {31'd0, mem.imem_req}, 32'd1);
            chk("dly_addr", {2'b0, mem.imem_addr}, 32'h0000_0C00);
            step();
        end
        chk("dly_req4", {31'd0, mem.imem_req}, 32'd1);
        mem.imem_ack = 1'b1; mem.imem_rdata = 32'h1111_2222;
        step();
        mem.imem_ack = 1'b0;
        chk("dly_valid", {31'd0, instr_valid}, 32'd1);
        chk("dly_instr", instr, 32'h1111_2222);

        // Stall in HOLD for 5 cycles, then commit to 0x3040
        stall = 1'b1; npc = 30'h0C10;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stl_pc", {2'b0, pc}, 32'h0000_0C00);
            chk("stl_instr", instr, 32'h1111_2222);
            chk("stl_cnt", retire_cnt, 32'd0);
        end
        // ack during HOLD must not overwrite instr
        mem.imem_ack = 1'b1; mem.imem_rdata = 32'hDEAD_BEEF;
        step();
        mem.imem_ack = 1'b0;
        chk("hold_ack_instr", instr, 32'h1111_2222);
        stall = 1'b0;
        step();
        chk("stl_new_pc", {2'b0, pc}, 32'h0000_0C10);
        chk("stl_new_req", {31'd0, mem.imem_req}, 32'd1);
        chk("stl_cnt1", retire_cnt, 32'd1);

        // Halt while stalled is ignored; commit then HALTED
        mem.imem_ack = 1'b1; mem.imem_rdata = 32'h3333_4444;
        step();
        mem.imem_ack = 1'b0;
        stall = 1'b1; halt = 1'b1; npc = 30'h0C20;
        step(); step();
        chk("hlt_stalled", {31'd0, halted}, 32'd0);
        chk("hlt_stalled_valid", {31'd0, instr_valid}, 32'd1);
        stall = 1'b0;
        step();
        halt = 1'b0;
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        chk("hlt_req", {31'd0, mem.imem_req}, 32'd0);
        chk("hlt_pc", {2'b0, pc}, 32'h0000_0C20);
        chk("hlt_cnt", retire_cnt, 32'd2);
        for (int i = 0; i < 3; i++) begin
            mem.imem_ack = 1'b1; mem.imem_rdata = 32'h5555_0000 + i;
            npc = 30'h0100;
            step();
            mem.imem_ack = 1'b0;
            step();
        end
        chk("hlt_instr", instr, 32'h3333_4444);
        chk("hlt_stay", {31'd0, halted}, 32'd1);
        chk("hlt_pc2", {2'b0, pc}, 32'h0000_0C20);
        chk("hlt_cnt2", retire_cnt, 32'd2);

        // Async reset mid-FETCH with ack in the same cycle
        rst = 1'b0; #1; rst = 1'b1;
        step();
        mem.imem_ack = 1'b1; mem.imem_rdata = 32'h7777_8888;
        step();
        mem.imem_ack = 1'b0; npc = 30'h0C01;
        step();
        chk("ar_pre_pc", {2'b0, pc}, 32'h0000_0C01);
        chk("ar_pre_cnt", retire_cnt, 32'd1);
        mem.imem_ack = 1'b1; mem.imem_rdata = 32'h9999_AAAA;
        #2; rst = 1'b0; #1;
        chk("ar_pc", {2'b0, pc}, 32'h0000_0C00);
        chk("ar_instr", instr, 32'd0);
        chk("ar_cnt", retire_cnt, 32'd0);
        chk("ar_valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk("ar_instr_held", instr, 32'd0);
        mem.imem_ack = 1'b0;
        rst = 1'b1;
        step();
        chk("ar_req", {31'd0, mem.imem_req}, 32'd1);
        chk("ar_addr", {2'b0, mem.imem_addr}, 32'h0000_0C00);

        // Self-loop npc==pc and counter wrap
        mem.imem_ack = 1'b1; mem.imem_rdata = 32'h0BAD_F00D;
        step();
        mem.imem_ack = 1'b0;
        stall = 1'b1; npc = 30'h0C00;
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        step();
        chk("wrap_pre", retire_cnt, 32'hFFFF_FFFF);
        stall = 1'b0;
        step();
        chk("wrap_cnt", retire_cnt, 32'd0);
        chk("loop_addr", {2'b0, mem.imem_addr}, 32'h0000_0C00);
        chk("loop_req", {31'd0, mem.imem_req}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
